// File: rtl/lcd_img_win_ctrl.sv
// Image-window controller: loads an IMG x IMG frame, then streams a WIN x WIN
// window (fit-subsampled or 1:1 crop, with pan and mirror) after every command.
module lcd_img_win_ctrl #(
    parameter int DW      = 8,
    parameter int IMG_LOG = 3,
    parameter int WIN_LOG = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] datain,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);
    localparam int IMG = 1 << IMG_LOG;
    localparam int WIN = 1 << WIN_LOG;
    localparam int N   = IMG * IMG;
    localparam int WW  = WIN * WIN;
    localparam int AW  = 2 * IMG_LOG;
    localparam int SH  = IMG_LOG - WIN_LOG;

    localparam logic [IMG_LOG-1:0] OMAX = IMG_LOG'(IMG - WIN);
    localparam logic [IMG_LOG-1:0] OCTR = IMG_LOG'((IMG - WIN) / 2);
    localparam logic [AW-1:0] LAST_PIX  = AW'(N - 1);
    localparam logic [AW-1:0] LAST_BEAT = AW'(WW - 1);

    localparam logic [3:0] C_LOAD  = 4'd1;
    localparam logic [3:0] C_ZOOM  = 4'd2;
    localparam logic [3:0] C_FIT   = 4'd3;
    localparam logic [3:0] C_RIGHT = 4'd4;
    localparam logic [3:0] C_LEFT  = 4'd5;
    localparam logic [3:0] C_UP    = 4'd6;
    localparam logic [3:0] C_DOWN  = 4'd7;
    localparam logic [3:0] C_MIRH  = 4'd8;
    localparam logic [3:0] C_MIRV  = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               vld_q, vld_d;
    logic [DW-1:0]      dout_q, dout_d;
    logic               zoom_q, zoom_d;
    logic               mh_q, mh_d;
    logic               mv_q, mv_d;
    logic [IMG_LOG-1:0] ox_q, ox_d;
    logic [IMG_LOG-1:0] oy_q, oy_d;

    logic [DW-1:0] mem [N];

    logic               accept;
    logic [WIN_LOG-1:0] bc, br, cc, rr;
    logic [IMG_LOG-1:0] px, py;
    logic [AW-1:0]      rd_addr;

    assign accept = cmd_valid && !busy_q && (state_q == S_IDLE);

    // WIN-1-c is the bitwise complement within a WIN_LOG-bit field
    assign bc = cnt_q[WIN_LOG-1:0];
    assign br = cnt_q[2*WIN_LOG-1:WIN_LOG];
    assign cc = mh_q ? ~bc : bc;
    assign rr = mv_q ? ~br : br;
    assign px = zoom_q ? (ox_q + IMG_LOG'(cc)) : {cc, {SH{1'b0}}};
    assign py = zoom_q ? (oy_q + IMG_LOG'(rr)) : {rr, {SH{1'b0}}};
    assign rd_addr = {py, px};

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD) mem[cnt_q] <= datain;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            dout_q  <= '0;
            zoom_q  <= 1'b0;
            mh_q    <= 1'b0;
            mv_q    <= 1'b0;
            ox_q    <= OCTR;
            oy_q    <= OCTR;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            dout_q  <= dout_d;
            zoom_q  <= zoom_d;
            mh_q    <= mh_d;
            mv_q    <= mv_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b1;
        vld_d   = 1'b0;
        dout_d  = dout_q;
        zoom_d  = zoom_q;
        mh_d    = mh_q;
        mv_d    = mv_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (accept) begin
                    busy_d  = 1'b1;
                    cmd_d   = cmd;
                    state_d = (cmd == C_LOAD) ? S_LOAD : S_CALC;
                end
            end
            S_LOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_PIX) begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                    zoom_d  = 1'b0;
                    mh_d    = 1'b0;
                    mv_d    = 1'b0;
                    ox_d    = OCTR;
                    oy_d    = OCTR;
                end
            end
            S_CALC: begin
                cnt_d   = '0;
                state_d = S_OUT;
                case (cmd_q)
                    C_ZOOM: begin
                        zoom_d = 1'b1;
                        ox_d   = OCTR;
                        oy_d   = OCTR;
                    end
                    C_FIT:   zoom_d = 1'b0;
                    C_RIGHT: if (zoom_q && ox_q < OMAX) ox_d = ox_q + 1'b1;
                    C_LEFT:  if (zoom_q && ox_q != '0) ox_d = ox_q - 1'b1;
                    C_UP:    if (zoom_q && oy_q != '0) oy_d = oy_q - 1'b1;
                    C_DOWN:  if (zoom_q && oy_q < OMAX) oy_d = oy_q + 1'b1;
                    C_MIRH:  mh_d = ~mh_q;
                    C_MIRV:  mv_d = ~mv_q;
                    default: ;
                endcase
            end
            S_OUT: begin
                vld_d  = 1'b1;
                dout_d = mem[rd_addr];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BEAT) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dataout      = dout_q;
    assign output_valid = vld_q;
    assign busy         = busy_q;
endmodule

// File: doc/lcd_img_win_ctrl.md
# lcd_img_win_ctrl

Parametrised LCD image-window controller. It loads a square image into an internal frame buffer and then streams a square output window to the panel driver. Viewing is controlled by commands: fit (subsampled) view, zoom-in (1:1 crop), clamped pan, and horizontal/vertical mirror. It sits between the host command/pixel interface and the LCD panel driver, and is the configurable next generation of the fixed 8x8/4x4 LCD controller.

## Interface
- DW, 8, pixel width in bits
- IMG_LOG, 3, log2 of image side; image is IMG = 2^IMG_LOG square, N = IMG*IMG pixels
- WIN_LOG, 2, log2 of window side; WIN = 2^WIN_LOG, must satisfy WIN_LOG < IMG_LOG; S = IMG/WIN is the fit stride
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- cmd  input  4  command code, sampled when cmd_valid && !busy
- cmd_valid  input  1  command strobe
- datain  input  DW  load pixel stream, raster order (row-major), address = y*IMG + x
- dataout  output  DW  window pixel, registered
- output_valid  output  1  high for exactly WIN*WIN consecutive beats per command
- busy  output  1  high while a command is in progress; commands are ignored while high

## Operation
- Command codes:
  - 0 REFRESH
  - 1 LOAD
  - 2 ZOOM_IN
  - 3 FIT
  - 4 RIGHT
  - 5 LEFT
  - 6 UP
  - 7 DOWN
  - 8 MIRROR_H (toggle)
  - 9 MIRROR_V (toggle)
  - 10-15 behave as REFRESH.
- Every command, LOAD included, ends with one full window output burst.
- State machine:
  - IDLE -> LOAD on cmd 1; IDLE -> CALC on any other accepted cmd.
  - LOAD -> OUT after N pixels.
  - CALC -> OUT after 1 cycle.
  - OUT -> IDLE after WIN*WIN beats.
- View state registers:
  - zoom (0 = fit, 1 = zoom-in)
  - origin ox, oy, each IMG_LOG bits
  - mh, mv mirror flags
- Reset and LOAD completion both set zoom = 0, ox = oy = (IMG-WIN)/2, mh = mv = 0.
- ZOOM_IN: zoom = 1 and origin re-centred to (IMG-WIN)/2, even if already zoomed in.
- FIT: zoom = 0. The origin is kept.
- Pan commands apply only when zoom = 1. The origin saturates to the range 0..IMG-WIN; at a limit it is unchanged. When zoom = 0, pans leave state unchanged but the burst is still emitted.
- Mirror toggles are valid in both zoom modes.
- Output beat b = r*WIN + c, with r, c in 0..WIN-1:
  - cc = mh ? WIN-1-c : c
  - rr = mv ? WIN-1-r : r
  - zoom = 1: pixel (ox+cc, oy+rr)
  - zoom = 0: pixel (cc*S, rr*S)
- Address arithmetic is in IMG_LOG-bit fields. Saturation guarantees no overflow, so no wrap-around occurs.
- The frame buffer is not cleared by reset; its contents before the first LOAD are undefined.

## Timing
- Reset values: dataout = 0, output_valid = 0, busy = 0; state IDLE; view registers as above.
- Acceptance happens at the edge T where cmd_valid && !busy. busy is 1 from T until the burst ends.
- LOAD:
  - datain for pixel k is sampled at edge T+1+k, for k = 0..N-1.
  - The first output_valid beat is visible after edge T+N+1.
  - Total busy time is N + WIN*WIN + 1 cycles.
- Other commands:
  - The view update is applied at T+1.
  - The first output beat is visible after edge T+2, and reflects the updated view.
- output_valid is continuous over the burst, with no gaps.
- busy and output_valid fall at the same edge after the last beat. A new command can be accepted at the following edge, giving a minimum of 1 idle cycle between bursts.
- cmd_valid while busy is ignored entirely: no state change and no queuing.
- dataout holds its last value when output_valid = 0.
- Reset asserted mid-LOAD or mid-OUT aborts at once: outputs return to reset values and the partially written buffer contents are undefined.

## Test plan
- Default parameters. LOAD with pixel k = k, then observe the burst: 0,2,4,6,16,18,20,22,32,34,36,38,48,50,52,54; busy high for 81 cycles.
- ZOOM_IN after the load: burst 18,19,20,21,26,27,28,29,34,35,36,37,42,43,44,45; first valid beat 2 cycles after acceptance.
- ZOOM_IN followed by RIGHT x3: origin saturates at x = 4; burst starts 20,21,22,23,28. UP x5 then saturates at y = 0; burst starts 4,5,6,7,12.
- ZOOM_IN then MIRROR_H: burst 21,20,19,18,29,28,27,26,... Then MIRROR_V: burst 45,44,43,42,37,... Then FIT: burst 54,52,50,48,38,...
- Pulse cmd_valid with cmd = 4 while busy during a burst: the burst is unchanged and no extra burst follows. cmd = 12 gives the same burst as REFRESH.
- Assert reset at LOAD pixel 30: outputs read 0 immediately. Reload with 255-k, then REFRESH: burst 255,253,251,...; view back to fit and centred.
